// File: rtl/bcd_disp_driver.sv
// bcd_disp_driver: two-digit multiplexed common-cathode seven-segment driver.
// A refresh counter toggles SegSel every REFRESH_DIV cycles; the segment
// register is loaded from the digit that SegSel is about to select, so the
// segments and SegSel always change together on the same edge.
module bcd_disp_driver #(
    parameter int REFRESH_DIV        = 1,
    parameter bit SEG_ACTIVE_LOW     = 1'b0,
    parameter bit BLANK_LEADING_ZERO = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Tens,
    input  logic [3:0] Ones,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       SegSel
);

    localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]      SEG_BLANK = {7{SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [6:0]       r_seg;

    logic             w_last;
    logic             w_sel_next;
    logic [3:0]       w_digit;
    logic             w_blank_tens;
    logic [6:0]       w_pattern;
    logic [6:0]       w_seg_next;

    assign w_last       = (r_cnt == CNT_LAST);
    assign w_sel_next   = w_last ? ~r_sel : r_sel;
    assign w_digit      = w_sel_next ? Tens : Ones;
    assign w_blank_tens = BLANK_LEADING_ZERO && w_sel_next && (Tens == 4'd0);

    // Decode the digit about to be shown; bit 6 = A ... bit 0 = G, active-high.
    always_comb begin
        w_pattern = '0;
        case (w_digit)
            4'd0:    w_pattern = 7'b1111110;
            4'd1:    w_pattern = 7'b0110000;
            4'd2:    w_pattern = 7'b1101101;
            4'd3:    w_pattern = 7'b1111001;
            4'd4:    w_pattern = 7'b0110011;
            4'd5:    w_pattern = 7'b1011011;
            4'd6:    w_pattern = 7'b1011111;
            4'd7:    w_pattern = 7'b1110000;
            4'd8:    w_pattern = 7'b1111111;
            4'd9:    w_pattern = 7'b1111011;
            default: w_pattern = '0;
        endcase
        if (w_blank_tens) begin
            w_pattern = '0;
        end
        w_seg_next = w_pattern ^ SEG_BLANK;
    end

    // Refresh counter, digit select and segment register share one edge.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
            r_seg <= SEG_BLANK;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            r_sel <= w_sel_next;
            r_seg <= w_seg_next;
        end
    end

    assign {A, B, C, D, E, F, G} = r_seg;
    assign SegSel                = r_sel;

endmodule

// File: tb/tb_bcd_disp_driver.sv
// tb_bcd_disp_driver: four parameterisations of bcd_disp_driver driven with
// the same inputs and checked against a string-table reference model.
module tb_bcd_disp_driver;

    logic       Clk;
    logic       Rst;
    logic [3:0] Tens;
    logic [3:0] Ones;

    logic [6:0] seg0, seg1, seg2, seg3;
    logic       sel0, sel1, sel2, sel3;

    int n_tests;
    int n_fail;
    int k;

    bcd_disp_driver #(.REFRESH_DIV(1), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b0)) u_d0 (
        .Clk(Clk), .Rst(Rst), .Tens(Tens), .Ones(Ones),
        .A(seg0[6]), .B(seg0[5]), .C(seg0[4]), .D(seg0[3]), .E(seg0[2]), .F(seg0[1]), .G(seg0[0]),
        .SegSel(sel0));

    bcd_disp_driver #(.REFRESH_DIV(1), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b1)) u_d1 (
        .Clk(Clk), .Rst(Rst), .Tens(Tens), .Ones(Ones),
        .A(seg1[6]), .B(seg1[5]), .C(seg1[4]), .D(seg1[3]), .E(seg1[2]), .F(seg1[1]), .G(seg1[0]),
        .SegSel(sel1));

    bcd_disp_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b0)) u_d2 (
        .Clk(Clk), .Rst(Rst), .Tens(Tens), .Ones(Ones),
        .A(seg2[6]), .B(seg2[5]), .C(seg2[4]), .D(seg2[3]), .E(seg2[2]), .F(seg2[1]), .G(seg2[0]),
        .SegSel(sel2));

    bcd_disp_driver #(.REFRESH_DIV(3), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b1)) u_d3 (
        .Clk(Clk), .Rst(Rst), .Tens(Tens), .Ones(Ones),
        .A(seg3[6]), .B(seg3[5]), .C(seg3[4]), .D(seg3[3]), .E(seg3[2]), .F(seg3[1]), .G(seg3[0]),
        .SegSel(sel3));

    // Free-running clock, period 10.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Lit-segment letters per digit, straight from the decode table.
    function automatic logic [6:0] seg_bits(input logic [3:0] d);
        string      lit [10];
        string      s;
        logic [6:0] p;
        byte        c;
        lit = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG",
                "ACDFG", "ACDEFG", "ABC", "ABCDEFG", "ABCDFG"};
        p = '0;
        if (d <= 4'd9) begin
            s = lit[d];
            for (int i = 0; i < s.len(); i++) begin
                c = s[i];
                p[6 - (int'(c) - 65)] = 1'b1;
            end
        end
        return p;
    endfunction

    // Expected {SegSel, ABCDEFG} after k edges since reset release.
    function automatic logic [7:0] model(input int div, input bit al, input bit blz,
                                         input int kk, input logic [3:0] t, input logic [3:0] o);
        logic       sel;
        logic [6:0] p;
        if (kk == 0) begin
            sel = 1'b0;
            p   = '0;
        end else begin
            sel = ((kk / div) % 2) == 1;
            if (sel && blz && t == 4'd0) p = '0;
            else                         p = seg_bits(sel ? t : o);
        end
        if (al) p = ~p;
        return {sel, p};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        check($sformatf("%s d0 k%0d T%0d O%0d", tag, k, Tens, Ones), {sel0, seg0}, e0);
        check($sformatf("%s d1 k%0d T%0d O%0d", tag, k, Tens, Ones), {sel1, seg1}, e1);
        check($sformatf("%s d2 k%0d T%0d O%0d", tag, k, Tens, Ones), {sel2, seg2}, e2);
        check($sformatf("%s d3 k%0d T%0d O%0d", tag, k, Tens, Ones), {sel3, seg3}, e3);
    endtask

    task automatic check_reset(input string tag);
        check_all(tag, model(1, 0, 0, 0, Tens, Ones), model(1, 0, 1, 0, Tens, Ones),
                       model(4, 1, 0, 0, Tens, Ones), model(3, 1, 1, 0, Tens, Ones));
    endtask

    // One clock edge: model computed from inputs held across the edge, sampled at negedge.
    task automatic cycle(input string tag);
        logic [7:0] e0, e1, e2, e3;
        @(posedge Clk);
        k++;
        e0 = model(1, 0, 0, k, Tens, Ones);
        e1 = model(1, 0, 1, k, Tens, Ones);
        e2 = model(4, 1, 0, k, Tens, Ones);
        e3 = model(3, 1, 1, k, Tens, Ones);
        @(negedge Clk);
        check_all(tag, e0, e1, e2, e3);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        k       = 0;
        Rst     = 1'b0;
        Tens    = 4'd1;
        Ones    = 4'd1;

        repeat (2) begin
            @(negedge Clk);
            check_reset("rst_hold");
        end
        Rst = 1'b1;
        k   = 0;

        repeat (6) cycle("t1o1");
        Tens = 4'd1; Ones = 4'd4;
        repeat (8) cycle("t1o4");
        Tens = 4'd0; Ones = 4'd8;
        repeat (8) cycle("t0o8");

        for (int t = 0; t < 16; t++) begin
            for (int o = 0; o < 16; o++) begin
                Tens = 4'(t);
                Ones = 4'(o);
                cycle("sweep");
            end
        end

        Tens = 4'd0; Ones = 4'd1;
        repeat (10) cycle("t0o1");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                Tens = 4'($urandom_range(0, 15));
                Ones = 4'($urandom_range(0, 15));
            end
            cycle("rand");
        end

        // Asynchronous reset landing between clock edges.
        @(posedge Clk);
        #2 Rst = 1'b0;
        #1 check_reset("rst_async");
        @(negedge Clk);
        check_reset("rst_async_hold");
        @(negedge Clk);
        check_reset("rst_async_hold2");
        Rst = 1'b1;
        k   = 0;
        Tens = 4'd7; Ones = 4'd2;
        repeat (12) cycle("after_rst");
        for (int i = 0; i < 40; i++) begin
            Tens = 4'($urandom_range(0, 9));
            Ones = 4'($urandom_range(0, 9));
            cycle("rand2");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_disp_driver.md
Name: bcd_disp_driver

Overview:
- Drives a two-digit multiplexed common-cathode seven-segment display from two BCD digits (Tens, Ones).
- Time-multiplexes the two digits onto one set of segment lines A–G, with SegSel choosing the lit digit.
- Sits between the BCD counter/arithmetic logic and the board display pins.
- All outputs are registered.

Parameters:
- REFRESH_DIV, 1, clock cycles per digit slot (≥1); SegSel toggles every REFRESH_DIV cycles.
- SEG_ACTIVE_LOW, 0, 0 = segment lit when output is 1; 1 = all A–G outputs inverted (blank = all 1).
- BLANK_LEADING_ZERO, 0, 1 = tens digit blanked when Tens == 0.

Ports:
- Clk     input   1  system clock; all state changes on the rising edge.
- Rst     input   1  reset, asynchronous, active-low.
- Tens    input   4  BCD tens digit (0–9 valid).
- Ones    input   4  BCD ones digit (0–9 valid).
- A       output  1  segment a (top), registered.
- B       output  1  segment b (upper right), registered.
- C       output  1  segment c (lower right), registered.
- D       output  1  segment d (bottom), registered.
- E       output  1  segment e (lower left), registered.
- F       output  1  segment f (upper left), registered.
- G       output  1  segment g (middle), registered.
- SegSel  output  1  digit select, registered; 0 = ones digit lit, 1 = tens digit lit.

Behaviour:
- Reset (Rst = 0, asynchronous): refresh counter cnt = 0, SegSel = 0, A–G = blank (all 0; all 1 if SEG_ACTIVE_LOW).
- Reset is held for as long as Rst is low. Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.
- Refresh counter cnt spans 0..REFRESH_DIV-1.
  - On each rising edge with cnt == REFRESH_DIV-1: cnt <= 0 and SegSel <= ~SegSel.
  - Otherwise: cnt <= cnt + 1.
  - With REFRESH_DIV = 1, SegSel toggles on every edge.
- Let nsel be the next-state value of SegSel. On every rising edge, A–G load decode(nsel ? Tens : Ones).
  - Segments and SegSel always change on the same edge and always match each other.
  - An input change appears on the segments at the next rising edge while its digit is selected (latency 1 cycle).
  - No glitch: segments never show the other digit's pattern while SegSel is stable.
- Decode table (segments lit, active-high):
  - 0: ABCDEF
  - 1: BC
  - 2: ABDEG
  - 3: ABCDG
  - 4: BCFG
  - 5: ACDFG
  - 6: ACDEFG
  - 7: ABC
  - 8: ABCDEFG
  - 9: ABCDFG
  - 10–15 (invalid BCD): blank, all segments off.
- When BLANK_LEADING_ZERO = 1 and Tens == 0, the tens slot is blank. The ones digit is never blanked except for invalid codes.
- When SEG_ACTIVE_LOW = 1, A–G are the bitwise inverse of the table above, including blank. SegSel polarity is unchanged.
- First edge after reset release: SegSel goes to 1 (when REFRESH_DIV = 1) and A–G show the Tens pattern.
- Inputs are used combinationally into the output registers with no extra input staging. Inputs must be synchronous to Clk.

Test Plan:
- Reset: hold Rst = 0 with Tens = 1, Ones = 1 for 2 clocks → SegSel = 0, A–G = 0000000 throughout. Assert Rst asynchronously mid-cycle → outputs blank immediately.
- Release Rst, Tens = 1, Ones = 1, REFRESH_DIV = 1 → SegSel alternates 1,0,1,… each edge. A–G = 0110000 (B,C) in both slots.
- Tens = 1, Ones = 4 → when SegSel = 1, ABCDEFG = 0110000. When SegSel = 0, ABCDEFG = 0110011 (B,C,F,G).
- Tens = 0, Ones = 8 → SegSel = 1 shows 1111110. SegSel = 0 shows 1111111. With BLANK_LEADING_ZERO = 1, the tens slot shows 0000000.
- Sweep both digits 0–15 → valid digits match the decode table in both slots. Values 10–15 are blank. Segment/SegSel pairing holds on every edge.
- REFRESH_DIV = 4, SEG_ACTIVE_LOW = 1 → SegSel period is 8 clocks. Ones = 1 gives A–G = 1001111 while SegSel = 0.
